// File: rtl/project01_cmp.sv
// project01 compare stage: registered WIDTH-bit magnitude compare.
// Define PROJECT01_CMP_SIGNED_EN to treat a and b as two's complement.
module project01_cmp #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [1:0]       r,
  output logic             out_valid
);

  localparam logic [1:0] REL_EQ = 2'b00;
  localparam logic [1:0] REL_LT = 2'b01;
  localparam logic [1:0] REL_GT = 2'b10;

  logic [1:0] code;

  // First differing bit from the MSB decides; later iterations win.
  always_comb begin
    code = REL_EQ;
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i] != b[i]) begin
        code = a[i] ? REL_GT : REL_LT;
      end
    end
`ifdef PROJECT01_CMP_SIGNED_EN
    if (a[WIDTH-1] != b[WIDTH-1]) begin
      code = a[WIDTH-1] ? REL_LT : REL_GT;
    end
`endif
  end

  // Result register; r only loads on a sampled pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r         <= REL_EQ;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        r <= code;
      end
    end
  end

endmodule

// File: tb/tb_project01_cmp.sv
// Directed bench for project01_cmp.
// Covers reset, directed pairs, hold, mid-stream reset and all pairs.
module tb_project01_cmp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] a = '0;
  logic [4:0] b = '0;
  logic [1:0] r;
  logic       out_valid;

  int errs = 0;
  int checks = 0;
  int seen11 = 0;

`ifdef PROJECT01_CMP_SIGNED_EN
  localparam logic [1:0] NEG_VS_POS = 2'b01;
`else
  localparam logic [1:0] NEG_VS_POS = 2'b10;
`endif

  project01_cmp #(.WIDTH(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .r(r),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] gold(input logic [4:0] x,
                                      input logic [4:0] y);
`ifdef PROJECT01_CMP_SIGNED_EN
    if ($signed(x) > $signed(y)) return 2'b10;
    if ($signed(x) < $signed(y)) return 2'b01;
`else
    if (x > y) return 2'b10;
    if (x < y) return 2'b01;
`endif
    return 2'b00;
  endfunction

  logic [4:0] va [5] = '{5'd6, 5'd9, 5'd0, 5'd1, 5'd2};
  logic [4:0] vb [5] = '{5'd8, 5'd9, 5'd0, 5'd0, 5'd1};
  logic [1:0] vr [5] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b10};

  initial begin
    // reset held with activity on the inputs
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 5'($urandom);
      b = 5'($urandom);
      step();
    end
    chk("rst_r", r, 2'b00);
    chk("rst_ov", out_valid, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_ov", out_valid, 1'b0);

    // directed back-to-back pairs
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = va[i];
      b = vb[i];
      step();
      chk($sformatf("dir%0d_r", i), r, vr[i]);
      chk($sformatf("dir%0d_ov", i), out_valid, 1'b1);
    end

    // boundaries
    a = 5'b11111; b = 5'b11111; step();
    chk("ones_eq", r, 2'b00);
    a = 5'b00000; b = 5'b00001; step();
    chk("lsb_lt", r, 2'b01);

    // hold while in_valid is low, including X operands
    a = 5'b11111; b = 5'b00000; step();
    chk("hold_load", r, NEG_VS_POS);
    in_valid = 1'b0;
    a = 5'd0; b = 5'd31;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        a = 'x;
        b = 'x;
      end
      step();
      chk($sformatf("hold%0d_r", i), r, NEG_VS_POS);
      chk($sformatf("hold%0d_ov", i), out_valid, 1'b0);
    end

    // async reset between edges
    in_valid = 1'b1;
    a = 5'd7; b = 5'd3; step();
    chk("pre_async_r", r, 2'b10);
    #3 rst_n = 1'b0;
    #1;
    chk("async_r", r, 2'b00);
    chk("async_ov", out_valid, 1'b0);
    step();
    rst_n = 1'b1;

    // reset mid-stream discards the sampled pair
    a = 5'd3; b = 5'd7;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_r", r, 2'b00);
    chk("mid_ov", out_valid, 1'b0);
    step();
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("mid_rel_r", r, 2'b00);
    chk("mid_rel_ov", out_valid, 1'b0);
    in_valid = 1'b1;
    a = 5'd7; b = 5'd3; step();
    chk("mid_resume_r", r, 2'b10);
    chk("mid_resume_ov", out_valid, 1'b1);

    // sign-sensitive vectors
    a = 5'b11111; b = 5'b00001; step();
    chk("sgn_m1_1", r, NEG_VS_POS);
    a = 5'b10000; b = 5'b01111; step();
    chk("sgn_min_max", r, NEG_VS_POS);

    // all pairs back-to-back
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        a = 5'(i);
        b = 5'(j);
        step();
        if (r == 2'b11) seen11++;
        chk($sformatf("ex_%0d_%0d", i, j), r, gold(5'(i), 5'(j)));
      end
    end
    chk("no_code11", seen11, 0);
    in_valid = 1'b0;
    step();
    chk("tail_ov", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/project01_cmp.md
Name: project01_cmp

Overview:
- Registered magnitude comparator for two WIDTH-bit operands (default 5).
- Produces a 2-bit relation code (equal / less / greater) one clock after operands are presented with in_valid.
- Used as the comparison stage in the project01 datapath.
- A combinational compare is followed by a single output register stage with a valid flag.

Parameters:
- WIDTH, 5, operand width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a and b are valid this cycle; sample them.
- a  input  WIDTH  operand A (unsigned by default).
- b  input  WIDTH  operand B (unsigned by default).
- r  output  2  relation code: 2'b00 a==b, 2'b01 a<b, 2'b10 a>b; 2'b11 never driven.
- out_valid  output  1  r holds the result of the most recent sampled pair.

Behaviour:
- Reset: when rst_n falls, r=2'b00 and out_valid=0 immediately, without waiting for clk. Both hold while rst_n=0.
- Compare rule:
  - Treat a and b as unsigned WIDTH-bit integers.
  - Evaluate MSB-first: the first differing bit decides. a_bit=1 gives greater; b_bit=1 gives less.
  - No differing bit gives equal.
- Latency: exactly 1 cycle.
  - On a rising clk edge with in_valid=1, r takes code(a,b) and out_valid=1.
  - On an edge with in_valid=0, r holds its previous value and out_valid=0.
- Back-to-back: in_valid may be high every cycle. Each edge produces an independent result; there are no bubbles and no stalls.
- Throughput: 1 compare per cycle. There is no backpressure.
- Reset mid-operation: any pair sampled before rst_n falls is discarded.
  - After rst_n rises, out_valid stays 0 until the first edge with in_valid=1.
- Code 2'b11 is unreachable in every mode.
- Boundaries:
  - All-zeros vs all-zeros gives 00.
  - All-ones vs all-ones gives 00.
  - All-ones vs all-zeros gives 10.
  - Operands differing only in the LSB are resolved correctly (e.g. 1 vs 0 gives 10).
- X on a or b while in_valid=0 must not disturb r.

Optional Feature:
- Macro: PROJECT01_CMP_SIGNED_EN.
- Defined: a and b are two's-complement WIDTH-bit values.
  - The MSB is the sign. If the signs differ, the negative operand is less.
  - If the signs match, the remaining bits are compared unsigned.
  - Encoding, latency and reset behaviour are unchanged.
- Undefined: pure unsigned compare as described above, with no sign logic in the netlist.

Test Plan:
- Reset: hold rst_n=0 with clk running and random a/b with in_valid=1 → r=00, out_valid=0. Assert rst_n=0 asynchronously between edges → outputs clear without a clock edge.
- Directed sequence, one pair per cycle, in_valid=1: (6,8), (9,9), (0,0), (1,0), (2,1).
  - Outputs one cycle later: 01, 00, 00, 10, 10.
  - out_valid=1 on each of those cycles.
- Hold: after a=5'b11111, b=5'b00000 (r=10), drop in_valid for 3 cycles with a=0, b=31 → r stays 10, out_valid=0.
- Reset mid-stream:
  - Drive (3,7) and assert rst_n=0 before the next edge → r=00, out_valid=0.
  - Release rst_n with in_valid=0 → outputs stay cleared.
  - Apply (7,3) → next cycle r=10.
- Exhaustive: all 1024 (a,b) pairs back-to-back → each r matches a golden unsigned compare one cycle later. Code 11 is never seen.
- Signed (PROJECT01_CMP_SIGNED_EN): (a=5'b11111, b=5'b00001) → r=01. Unsigned build gives 10. (5'b10000, 5'b01111) → signed 01 / unsigned 10.
